// File: rtl/text_buffer_pkg.sv
// Shared constants for the terminal text screen store and its controller.
package text_buffer_pkg;

    localparam int unsigned TEXT_ADDR_W = 10;
    localparam int unsigned TEXT_DATA_W = 8;
    localparam int unsigned TEXT_COLS   = 40;
    localparam logic [7:0]  TEXT_FILL   = 8'h20;

    // Clear sequencer states
    typedef enum logic {
        ST_CLEAR,
        ST_RUN
    } text_state_t;

endpackage

// File: rtl/ram_sp_1024x8.sv
// Single-port synchronous read-first RAM; no reset so it maps onto block RAM.
module ram_sp_1024x8 #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] a,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Read returns the old contents; the write lands on the same edge.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[a] <= d;
        end
        q <= r_mem[a];
    end

endmodule

// File: rtl/text_buffer.sv
// Text screen character store: clears every cell to FILL after reset, then
// serves one single-cycle read (and optional write) per clock.
module text_buffer
    import text_buffer_pkg::*;
#(
    parameter int unsigned      ADDR_W = TEXT_ADDR_W,
    parameter int unsigned      DATA_W = TEXT_DATA_W,
    parameter logic [DATA_W-1:0] FILL  = DATA_W'(TEXT_FILL)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wen,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              busy
);

    text_state_t       r_state;
    logic [ADDR_W-1:0] r_ptr;
    logic              r_busy;
    logic              r_rd_en;

    logic              w_we;
    logic [ADDR_W-1:0] w_a;
    logic [DATA_W-1:0] w_d;
    logic [DATA_W-1:0] w_q;

    // Clear/run sequencer; r_rd_en marks that the last edge was a user read.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_CLEAR;
            r_ptr   <= '0;
            r_busy  <= 1'b1;
            r_rd_en <= 1'b0;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    r_ptr   <= r_ptr + 1'b1;
                    r_rd_en <= 1'b0;
                    if (r_ptr == '1) begin
                        r_state <= ST_RUN;
                        r_busy  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    r_rd_en <= 1'b1;
                end
                default: begin
                    r_state <= ST_CLEAR;
                    r_ptr   <= '0;
                    r_busy  <= 1'b1;
                    r_rd_en <= 1'b0;
                end
            endcase
        end
    end

    // RAM port mux: sequencer owns the array during the clear, user afterwards.
    always_comb begin
        w_we = 1'b0;
        w_a  = addr;
        w_d  = wdata;
        if (!rst) begin
            if (r_state == ST_CLEAR) begin
                w_we = 1'b1;
                w_a  = r_ptr;
                w_d  = FILL;
            end else begin
                w_we = wen;
            end
        end
    end

    ram_sp_1024x8 #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk (clk),
        .we  (w_we),
        .a   (w_a),
        .d   (w_d),
        .q   (w_q)
    );

    // RAM q is gated by a registered flag so rdata stays 0 through reset and
    // the clear, including the edge that ends it.
    assign rdata = r_rd_en ? w_q : '0;
    assign busy  = r_busy;

endmodule

// File: tb/tb_text_buffer.sv
// Self-checking bench for text_buffer: per-cycle model comparison plus
// directed literal checks.
module tb_text_buffer;

    localparam int DEPTH = 1024;
    localparam logic [7:0] FILLC = 8'h20;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wen = 1'b0;
    logic [9:0] addr = '0;
    logic [7:0] wdata = '0;
    logic [7:0] rdata;
    logic       busy;

    int checks = 0;
    int failures = 0;

    text_buffer #(
        .ADDR_W (10),
        .DATA_W (8),
        .FILL   (8'h20)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .wen   (wen),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: cells still to be cleared, plus a plain memory array.
    logic [7:0] mm [DEPTH];
    int         left = 0;
    bit         valid = 0;
    logic [7:0] e_rd = '0;
    logic       e_busy = 1'b1;

    always @(posedge clk) begin
        if (rst) begin
            left   = DEPTH;
            e_rd   = '0;
            e_busy = 1'b1;
            valid  = 1;
        end else if (valid) begin
            if (left > 0) begin
                mm[DEPTH-left] = FILLC;
                left--;
                e_busy = (left != 0);
                e_rd   = '0;
            end else begin
                e_rd = mm[addr];
                if (wen) mm[addr] = wdata;
            end
        end
        #1;
        if (valid) begin
            chk("model_busy", {31'd0, busy}, {31'd0, e_busy});
            if (!$isunknown(e_rd)) chk("model_rdata", {24'd0, rdata}, {24'd0, e_rd});
        end
    end

    // Drive inputs for the next rising edge.
    task automatic cyc(input logic w, input logic [9:0] a, input logic [7:0] d);
        @(negedge clk);
        wen = w; addr = a; wdata = d;
    endtask

    task automatic read_chk(input string name, input logic [9:0] a, input logic [7:0] exp);
        cyc(1'b0, a, 8'h00);
        @(posedge clk); #2;
        chk(name, {24'd0, rdata}, {24'd0, exp});
    endtask

    // Counts edges after release until busy drops; also tracks rdata during clear.
    task automatic wait_clear(output int n, output bit rd_zero);
        n = 0;
        rd_zero = 1;
        while (n < 2000) begin
            @(posedge clk); #2;
            n++;
            if (rdata !== 8'h00) rd_zero = 0;
            if (busy === 1'b0) break;
        end
    endtask

    int  n;
    bit  rz;
    logic [9:0] a10;

    initial begin
        // Reset held for 3 cycles
        @(negedge clk);
        rst = 1; wen = 0;
        repeat (3) @(posedge clk);
        #2;
        chk("reset_busy", {31'd0, busy}, 32'd1);
        chk("reset_rdata", {24'd0, rdata}, 32'h0);

        // Release with a write attempt to addr 5 during the clear
        @(negedge clk);
        rst = 0; wen = 1; addr = 10'd5; wdata = 8'hFF;
        wait_clear(n, rz);
        chk("clear_len", n, 32'd1024);
        chk("clear_rdata_zero", {31'd0, rz}, 32'd1);
        chk("post_clear_rdata", {24'd0, rdata}, 32'h0);

        read_chk("rd_0", 10'd0, 8'h20);
        read_chk("rd_288", 10'd288, 8'h20);
        read_chk("rd_1023", 10'd1023, 8'h20);
        read_chk("rd_5_ignored_write", 10'd5, 8'h20);

        // Write/read and neighbours
        cyc(1'b1, 10'd288, 8'h41);
        read_chk("rd_288_new", 10'd288, 8'h41);
        read_chk("rd_287", 10'd287, 8'h20);
        read_chk("rd_289", 10'd289, 8'h20);

        // Read-first collision
        cyc(1'b1, 10'd10, 8'h55);
        cyc(1'b1, 10'd10, 8'hAA);
        @(posedge clk); #2;
        chk("collision_old", {24'd0, rdata}, 32'h55);
        read_chk("collision_new", 10'd10, 8'hAA);

        // Reset mid-clear
        @(negedge clk);
        rst = 1; wen = 0;
        @(negedge clk);
        rst = 0;
        repeat (500) @(posedge clk);
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        wait_clear(n, rz);
        chk("reclear_len", n, 32'd1024);
        chk("reclear_rdata_zero", {31'd0, rz}, 32'd1);
        for (int i = 0; i < DEPTH; i++) begin
            a10 = 10'(i);
            cyc(1'b0, a10, 8'h00);
            @(posedge clk); #2;
            if (rdata !== 8'h20) chk("reclear_cell", {22'd0, a10}, 32'hFFFF_FFFF);
        end
        checks++;

        // Back-to-back writes then reads, data = addr[7:0]
        for (int i = 0; i < DEPTH; i++) begin
            a10 = 10'(i);
            cyc(1'b1, a10, a10[7:0]);
        end
        for (int i = 0; i < DEPTH; i++) begin
            a10 = 10'(i);
            cyc(1'b0, a10, 8'h00);
            @(posedge clk); #2;
            chk("b2b_read", {24'd0, rdata}, {24'd0, a10[7:0]});
        end
        read_chk("b2b_last", 10'd1023, 8'hFF);

        @(negedge clk);
        wen = 0;
        repeat (2) @(posedge clk);
        #3;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got running expected finished");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
